// File: rtl/sram_fifo_ctrl_pkg.sv
// sram_fifo_ctrl_pkg
// Shared defaults for the SRAM-backed FWFT FIFO controller.
//   DEF_AWIDTH : default SRAM address width (depth = 2^DEF_AWIDTH)
//   DEF_DWIDTH : default data word width
package sram_fifo_ctrl_pkg;
   localparam int DEF_AWIDTH = 12;
   localparam int DEF_DWIDTH = 72;
endpackage

// File: rtl/sram_fifo_ctrl.sv
// sram_fifo_ctrl
// First-word-fall-through FIFO controller around a dual-port SRAM macro
// (1-cycle write, combinational read). One extra word is held in the
// m_data output register, so capacity is 2^AWIDTH + 1 words.
// Ports:
//   clk, rstb              : clock, asynchronous active-low reset
//   flush                  : synchronous clear, overrides push/pop
//   s_valid/s_ready/s_data : upstream valid/ready slave port
//   m_valid/m_ready/m_data : downstream registered valid/ready master port
//   level                  : words held (SRAM + output register)
//   ram_*                  : SRAM macro pins, wired one-to-one
module sram_fifo_ctrl
   import sram_fifo_ctrl_pkg::*;
#(
   parameter int AWIDTH = DEF_AWIDTH,
   parameter int DWIDTH = DEF_DWIDTH
) (
   input  logic              clk,
   input  logic              rstb,
   input  logic              flush,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [DWIDTH-1:0] s_data,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [DWIDTH-1:0] m_data,
   output logic [AWIDTH+1:0] level,
   output logic              ram_mem_en,
   output logic              ram_wea,
   output logic              ram_regceb,
   output logic [DWIDTH-1:0] ram_dina,
   output logic [AWIDTH-1:0] ram_addra,
   output logic [AWIDTH-1:0] ram_addrb,
   input  logic [DWIDTH-1:0] ram_doutb
);

   localparam int PW = AWIDTH + 1;
   localparam int LW = AWIDTH + 2;
   localparam logic [PW-1:0] FULL_CNT = {1'b1, {AWIDTH{1'b0}}};

   logic [PW-1:0]     r_wr_ptr;
   logic [PW-1:0]     r_rd_ptr;
   logic              r_rdy;
   logic              r_m_valid;
   logic [DWIDTH-1:0] r_m_data;
   logic [LW-1:0]     r_level;

   logic [PW-1:0]     w_sram_cnt;
   logic              w_sram_full;
   logic              w_sram_empty;
   logic              w_push;
   logic              w_pop_out;
   logic              w_fetch;

   // Full/empty use registered pointers only, so a word written this
   // cycle is never visible to the read side until after the edge.
   assign w_sram_cnt   = r_wr_ptr - r_rd_ptr;
   assign w_sram_full  = (w_sram_cnt == FULL_CNT);
   assign w_sram_empty = (r_wr_ptr == r_rd_ptr);

   assign s_ready   = r_rdy & ~w_sram_full & ~flush;
   assign w_push    = s_valid & s_ready;
   assign w_pop_out = r_m_valid & m_ready;
   // Refill the output register when it is empty or being drained.
   assign w_fetch   = r_rdy & ~w_sram_empty & ~flush & (~r_m_valid | m_ready);

   assign ram_wea    = w_push;
   assign ram_regceb = w_fetch;
   assign ram_mem_en = w_push | w_fetch;
   assign ram_dina   = s_data;
   assign ram_addra  = r_wr_ptr[AWIDTH-1:0];
   assign ram_addrb  = r_rd_ptr[AWIDTH-1:0];

   assign m_valid = r_m_valid;
   assign m_data  = r_m_data;
   assign level   = r_level;

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         r_rdy     <= 1'b0;
         r_wr_ptr  <= '0;
         r_rd_ptr  <= '0;
         r_m_valid <= 1'b0;
         r_m_data  <= '0;
         r_level   <= '0;
      end else begin
         r_rdy <= 1'b1;
         if (flush) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_m_valid <= 1'b0;
            r_level   <= '0;
         end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_fetch) begin
               r_rd_ptr  <= r_rd_ptr + PW'(1);
               r_m_data  <= ram_doutb;
               r_m_valid <= 1'b1;
            end else if (w_pop_out) begin
               r_m_valid <= 1'b0;
            end
            // A fetch only moves a word from SRAM to the output register,
            // so the total changes only by push in and pop out.
            r_level <= r_level + LW'(w_push) - LW'(w_pop_out);
         end
      end
   end

endmodule
